i2c_master_wr: RTL and testbench

- Single-byte I2C write master that generates the bus traffic consumed by the team's I2C slave receiver.
- Transaction: START, 7-bit address + R/W=0, ACK check, 8-bit data, ACK check, STOP.
- Sits between a local request interface (start/addr/wdata) and the open-drain SDA/SCL pads.
- Drives SCL from a programmable quarter-bit timebase.

---
 rtl/i2c_master_wr_if.sv | 24 ++
 rtl/i2c_master_wr.sv | 152 +++++++++++++++
 tb/tb_i2c_master_wr.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_wr_if.sv
// Request/status and open-drain pad signals of the single-byte I2C write master.
// Names are from the master's point of view; the slave modport is the user/pad side.
interface i2c_master_wr_if;
  logic       i_start;
  logic [6:0] i_addr;
  logic [7:0] i_wdata;
  logic       o_busy;
  logic       o_done;
  logic       o_ack_err;
  logic       o_scl_out;
  logic       o_sda_out;
  logic       i_sda_in;
  logic       i_scl_in;

  modport master (
    input  i_start, i_addr, i_wdata, i_sda_in, i_scl_in,
    output o_busy, o_done, o_ack_err, o_scl_out, o_sda_out
  );

  modport slave (
    output i_start, i_addr, i_wdata, i_sda_in, i_scl_in,
    input  o_busy, o_done, o_ack_err, o_scl_out, o_sda_out
  );
endinterface

// File: rtl/i2c_master_wr.sv
// Single-byte I2C write master: START, addr+W, ACK, data, ACK, STOP on a quarter-bit timebase.
// Optional slave clock stretching is enabled by defining I2C_MASTER_CLKSTRETCH_EN.
module i2c_master_wr #(
  parameter int unsigned QTR_CYCLES = 25
) (
  input  logic            clk,
  input  logic            reset,
  i2c_master_wr_if.master bus
);

  localparam logic [15:0] QTR_LAST = 16'(QTR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK1,
    DATA,
    ACK2,
    STOP
  } state_t;

  state_t      r_state;
  logic [1:0]  r_q;
  logic [15:0] r_qcnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_wdata;
  logic        r_busy;
  logic        r_done;
  logic        r_ack_err;
  logic        r_scl;
  logic        r_sda;

  logic w_hold;
  logic w_tick;

`ifdef I2C_MASTER_CLKSTRETCH_EN
  // Slave holds SCL low while we release it during the high half of a bit.
  assign w_hold = r_q[1] & r_scl & ~bus.i_scl_in;
`else
  logic w_unused_scl_in;
  assign w_unused_scl_in = bus.i_scl_in;
  assign w_hold          = 1'b0;
`endif

  assign w_tick = r_busy && !w_hold && (r_qcnt == QTR_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_q       <= 2'd0;
      r_qcnt    <= 16'd0;
      r_bit     <= 3'd0;
      r_shift   <= 8'd0;
      r_wdata   <= 8'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_scl     <= 1'b1;
      r_sda     <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (bus.i_start) begin
          r_busy    <= 1'b1;
          r_state   <= START;
          r_shift   <= {bus.i_addr, 1'b0};
          r_wdata   <= bus.i_wdata;
          r_ack_err <= 1'b0;
          r_q       <= 2'd0;
          r_qcnt    <= 16'd0;
          r_bit     <= 3'd0;
        end
      end else if (w_tick) begin
        r_qcnt <= 16'd0;
        r_q    <= r_q + 2'd1;
        // Line levels are set on the tick that enters the next quarter.
        case (r_q)
          2'd1: begin
            r_scl <= 1'b1;
            if (r_state == START) r_sda <= 1'b0;
          end
          2'd2: begin
            if (r_state == STOP) r_sda <= 1'b1;
            if ((r_state == ACK1 || r_state == ACK2) && bus.i_sda_in) r_ack_err <= 1'b1;
          end
          2'd3: begin
            case (r_state)
              START: begin
                r_state <= ADDR;
                r_scl   <= 1'b0;
                r_sda   <= r_shift[7];
              end
              ADDR, DATA: begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_scl   <= 1'b0;
                if (r_bit == 3'd7) begin
                  r_bit   <= 3'd0;
                  r_state <= (r_state == ADDR) ? ACK1 : ACK2;
                  r_sda   <= 1'b1;
                end else begin
                  r_bit <= r_bit + 3'd1;
                  r_sda <= r_shift[6];
                end
              end
              ACK1: begin
                r_scl <= 1'b0;
                if (r_ack_err) begin
                  r_state <= STOP;
                  r_sda   <= 1'b0;
                end else begin
                  r_state <= DATA;
                  r_shift <= r_wdata;
                  r_sda   <= r_wdata[7];
                end
              end
              ACK2: begin
                r_state <= STOP;
                r_scl   <= 1'b0;
                r_sda   <= 1'b0;
              end
              STOP: begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_scl   <= 1'b1;
                r_sda   <= 1'b1;
              end
              default: begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_scl   <= 1'b1;
                r_sda   <= 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end else if (!w_hold) begin
        r_qcnt <= r_qcnt + 16'd1;
      end
    end
  end

  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_ack_err = r_ack_err;
  assign bus.o_scl_out = r_scl;
  assign bus.o_sda_out = r_sda;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: acts as requester and as an open-drain slave that ACKs/NACKs,
// decodes SCL-rising-edge SDA levels and compares them with a byte-level expectation.
module tb_i2c_master_wr;
  localparam int QTR = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_master_wr_if bus();

  i2c_master_wr #(.QTR_CYCLES(QTR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [6:0] addr;
    logic [7:0] wdata;
    bit         ack_a;
    bit         ack_d;
    int         exp_lat;
    bit         exp_err;
  } vec_t;

  vec_t vecs[4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // bus monitor / slave model state
  logic [31:0] cap;
  int          cap_n;
  int          fall_cnt;
  int          start_cnt;
  int          stop_cnt;
  int          done_cnt;
  int          busy_cyc;
  int          done_cyc;
  bit          cur_aa;
  bit          cur_ad;
  bit          stretch_arm;
  int          stretch_left;
  logic        prev_scl  = 1'b1;
  logic        prev_line = 1'b1;
  logic        prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected SDA level at every SCL rising edge: address, W, ack, [data, ack], STOP.
  function automatic void build_exp(input logic [6:0] a, input logic [7:0] d, input bit aa,
                                    input bit ad, output logic [31:0] e, output int n);
    e = '0;
    n = 0;
    for (int i = 6; i >= 0; i--) begin e = {e[30:0], a[i]}; n++; end
    e = {e[30:0], 1'b0}; n++;
    e = {e[30:0], ~aa};  n++;
    if (aa) begin
      for (int i = 7; i >= 0; i--) begin e = {e[30:0], d[i]}; n++; end
      e = {e[30:0], ~ad}; n++;
    end
    e = {e[30:0], 1'b0}; n++;
  endfunction

  task automatic clear_mon(input bit aa, input bit ad, input bit stretch);
    cap = '0; cap_n = 0; fall_cnt = 0; start_cnt = 0; stop_cnt = 0; done_cnt = 0;
    busy_cyc = -1; done_cyc = -1; cur_aa = aa; cur_ad = ad;
    stretch_arm = stretch; stretch_left = 0;
  endtask

  task automatic step();
    logic scl, line;
    bit   pull;
    @(negedge clk);
    cyc++;
    scl = bus.o_scl_out;
    if (!scl && prev_scl) fall_cnt++;
    pull = (cur_aa && fall_cnt == 9) || (cur_ad && fall_cnt == 18);
    line = bus.o_sda_out & ~pull;
    if (scl && !prev_scl) begin
      cap = {cap[30:0], line};
      cap_n++;
      if (stretch_arm && cap_n == 4) begin stretch_left = 50; stretch_arm = 0; end
    end
    if (scl && prev_scl && prev_line && !line) start_cnt++;
    if (scl && prev_scl && !prev_line && line) stop_cnt++;
    if (bus.o_busy && !prev_busy) busy_cyc = cyc;
    if (bus.o_done) begin done_cnt++; done_cyc = cyc; end
    bus.i_sda_in = line;
    if (stretch_left > 0) begin bus.i_scl_in = 1'b0; stretch_left--; end
    else bus.i_scl_in = scl;
    prev_scl  = scl;
    prev_line = line;
    prev_busy = bus.o_busy;
  endtask

  task automatic run_xfer(input logic [6:0] a, input logic [7:0] d, input bit aa, input bit ad,
                          input bit stretch, input int inject_at, input int tail,
                          input int exp_lat, input bit exp_err, input string tag);
    logic [31:0] e;
    int          en;
    int          steps;
    build_exp(a, d, aa, ad, e, en);
    clear_mon(aa, ad, stretch);
    bus.i_addr  = a;
    bus.i_wdata = d;
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    check({tag, " busy_after_accept"}, 32'(bus.o_busy), 32'd1);
    check({tag, " ack_err_cleared"}, 32'(bus.o_ack_err), 32'd0);
    steps = 0;
    while (done_cnt == 0 && steps < 3000) begin
      if (steps == inject_at) begin
        bus.i_start = 1'b1; bus.i_addr = 7'h12; bus.i_wdata = 8'h34;
      end
      step();
      bus.i_start = 1'b0;
      steps++;
    end
    check({tag, " done_seen"}, 32'(done_cnt), 32'd1);
    check({tag, " latency"}, 32'(done_cyc - busy_cyc), 32'(exp_lat));
    check({tag, " ack_err"}, 32'(bus.o_ack_err), 32'(exp_err));
    check({tag, " busy_at_done"}, 32'(bus.o_busy), 32'd0);
    check({tag, " lines_at_done"}, 32'({bus.o_scl_out, bus.o_sda_out}), 32'd3);
    check({tag, " bit_count"}, 32'(cap_n), 32'(en));
    check({tag, " bits"}, cap, e);
    check({tag, " start_cond"}, 32'(start_cnt), 32'd1);
    check({tag, " stop_cond"}, 32'(stop_cnt), 32'd1);
    if (tail > 0) begin
      repeat (tail) step();
      check({tag, " single_done"}, 32'(done_cnt), 32'd1);
      check({tag, " idle_after"}, 32'(bus.o_busy), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{addr: 7'h50, wdata: 8'hA5, ack_a: 1'b1, ack_d: 1'b1, exp_lat: 80*QTR, exp_err: 1'b0};
    vecs[1] = '{addr: 7'h7F, wdata: 8'h00, ack_a: 1'b0, ack_d: 1'b0, exp_lat: 44*QTR, exp_err: 1'b1};
    vecs[2] = '{addr: 7'h2A, wdata: 8'hFF, ack_a: 1'b1, ack_d: 1'b0, exp_lat: 80*QTR, exp_err: 1'b1};
    vecs[3] = '{addr: 7'h00, wdata: 8'h81, ack_a: 1'b1, ack_d: 1'b1, exp_lat: 80*QTR, exp_err: 1'b0};

    reset        = 1'b1;
    bus.i_start  = 1'b0;
    bus.i_addr   = '0;
    bus.i_wdata  = '0;
    bus.i_sda_in = 1'b1;
    bus.i_scl_in = 1'b1;
    clear_mon(1'b0, 1'b0, 1'b0);
    repeat (3) step();
    check("reset busy", 32'(bus.o_busy), 32'd0);
    check("reset done", 32'(bus.o_done), 32'd0);
    check("reset ack_err", 32'(bus.o_ack_err), 32'd0);
    check("reset scl", 32'(bus.o_scl_out), 32'd1);
    check("reset sda", 32'(bus.o_sda_out), 32'd1);
    reset = 1'b0;
    repeat (2) step();

    // Table vectors run back-to-back: each start lands on the previous done cycle.
    for (int i = 0; i < 4; i++)
      run_xfer(vecs[i].addr, vecs[i].wdata, vecs[i].ack_a, vecs[i].ack_d, 1'b0, -1, 0,
               vecs[i].exp_lat, vecs[i].exp_err, $sformatf("vec%0d", i));
    repeat (5) step();

    // NACK then immediate restart: ack_err must clear on the second accept.
    run_xfer(7'h11, 8'h22, 1'b0, 1'b0, 1'b0, -1, 0, 44*QTR, 1'b1, "b2b_nack");
    run_xfer(7'h33, 8'h44, 1'b1, 1'b1, 1'b0, -1, 4, 80*QTR, 1'b0, "b2b_ack");

    run_xfer(7'h3C, 8'h5A, 1'b1, 1'b1, 1'b0, 50, 20, 80*QTR, 1'b0, "ignore_busy_start");

    for (int i = 0; i < 6; i++) begin
      logic [6:0] ra;
      logic [7:0] rd;
      bit         raa, rad;
      ra  = 7'($urandom_range(0, 127));
      rd  = 8'($urandom_range(0, 255));
      raa = ($urandom_range(0, 3) != 0);
      rad = ($urandom_range(0, 3) != 0);
      run_xfer(ra, rd, raa, rad, 1'b0, -1, int'($urandom_range(0, 3)),
               raa ? 80*QTR : 44*QTR, !(raa && rad), $sformatf("rand%0d", i));
    end
    repeat (3) step();

    // Reset roughly 100 cycles into a transfer.
    clear_mon(1'b1, 1'b1, 1'b0);
    bus.i_addr  = 7'h33;
    bus.i_wdata = 8'hCC;
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    repeat (99) step();
    check("midrst busy_before", 32'(bus.o_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst scl", 32'(bus.o_scl_out), 32'd1);
    check("midrst sda", 32'(bus.o_sda_out), 32'd1);
    check("midrst busy", 32'(bus.o_busy), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    repeat (300) step();
    check("midrst no_done", 32'(done_cnt), 32'd0);
    check("midrst idle", 32'(bus.o_busy), 32'd0);
    run_xfer(7'h50, 8'hA5, 1'b1, 1'b1, 1'b0, -1, 3, 80*QTR, 1'b0, "after_reset");

`ifdef I2C_MASTER_CLKSTRETCH_EN
    run_xfer(7'h50, 8'hA5, 1'b1, 1'b1, 1'b1, -1, 3, 80*QTR + 50, 1'b0, "stretch");
`else
    run_xfer(7'h50, 8'hA5, 1'b1, 1'b1, 1'b1, -1, 3, 80*QTR, 1'b0, "stretch_ignored");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
